// File: rtl/apb_gpio_pkg.sv
// Shared types and constants for the APB-to-GPIO register port bridge.
package apb_gpio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrAcc,
    StRdWait,
    StRdDone,
    StErr
  } state_e;

  localparam logic [1:0] REGSEL_PIN  = 2'b00;
  localparam logic [1:0] REGSEL_DIR  = 2'b10;
  localparam logic [1:0] REGSEL_PORT = 2'b11;

  localparam logic [3:0] OFF_PIN  = 4'h0;
  localparam logic [3:0] OFF_DIR  = 4'h4;
  localparam logic [3:0] OFF_PORT = 4'h8;

endpackage

// File: rtl/apb_gpio_bridge.sv
// APB3 slave that turns APB transfers into GPIO register-port strobes, adding
// wait states for GPIO read latency and flagging illegal accesses with PSLVERR.
module apb_gpio_bridge
  import apb_gpio_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              gpio_busw,
  output logic [1:0]        gpio_regsel,
  output logic [7:0]        gpio_wdata,
  input  logic [7:0]        gpio_rdata
);

  localparam logic [1:0] CntInit = 2'(RD_LAT);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] regsel_q, regsel_d;
  logic [7:0] wdata_q, wdata_d;

  logic       dec_err;
  logic [1:0] dec_sel;

  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[31:8];

  always_comb begin
    dec_err = 1'b0;
    dec_sel = REGSEL_PIN;
    case (paddr[3:0])
      OFF_PIN:  dec_err = pwrite;
      OFF_DIR:  dec_sel = REGSEL_DIR;
      OFF_PORT: dec_sel = REGSEL_PORT;
      default:  dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    regsel_d = regsel_q;
    wdata_d  = wdata_q;
    case (state_q)
      StIdle: begin
        // Only a genuine setup phase starts a transfer; stray penable is ignored.
        if (psel && !penable) begin
          wdata_d  = pwdata[7:0];
          regsel_d = dec_err ? REGSEL_PIN : dec_sel;
          cnt_d    = CntInit;
          if (dec_err) begin
            state_d = StErr;
          end else if (pwrite) begin
            state_d = StWrAcc;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StWrAcc: state_d = StIdle;
      StRdWait: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (cnt_q <= 2'd1) begin
          state_d = StRdDone;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StRdDone: state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Register select parks on PIN whenever the bridge is idle.
    if (state_d == StIdle) begin
      regsel_d = REGSEL_PIN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      regsel_q <= REGSEL_PIN;
      wdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      regsel_q <= regsel_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    pready      = (state_q == StWrAcc) || (state_q == StRdDone) || (state_q == StErr);
    pslverr     = (state_q == StErr);
    gpio_busw   = (state_q == StWrAcc);
    prdata      = (state_q == StRdDone) ? {24'h0, gpio_rdata} : 32'h0;
    gpio_regsel = regsel_q;
    gpio_wdata  = wdata_q;
  end

endmodule
